// File: rtl/crossbar_row_loader.sv
// crossbar_row_loader: after a rising edge on start_load, takes exactly ROWS
// words from a valid/ready stream and writes them to crossbar rows 0..ROWS-1
// through a registered write port. It then pulses done for one cycle.
module crossbar_row_loader #(
  parameter int DATA_W = 32,
  parameter int ROWS   = 16,
  parameter int ADDR_W = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_load,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   load_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

  state_t              state_q, state_d;
  logic                start_prev_q;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     load_count_q, load_count_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                start_edge;
  logic                ready_int;
  logic                accept;

  // Edge detect, handshake qualification, next-state and write-port logic
  always_comb begin
    start_edge   = start_load & ~start_prev_q;
    ready_int    = (state_q == LOAD) & ~abort;
    accept       = ready_int & in_valid;

    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    load_count_d = load_count_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d      = LOAD;
          wr_ptr_d     = '0;
          load_count_d = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          mem_we_d     = 1'b1;
          mem_addr_d   = wr_ptr_q;
          mem_wdata_d  = in_data;
          wr_ptr_d     = wr_ptr_q + 1'b1;
          load_count_d = load_count_q + 1'b1;
          if (wr_ptr_q == LAST_ROW) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and write-port registers. start_prev keeps tracking start_load
  // through reset, so a level held across reset release is not taken as a
  // new request.
  always_ff @(posedge clk) begin
    start_prev_q <= start_load;
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      load_count_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      load_count_q <= load_count_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign in_ready   = ready_int;
  assign busy       = (state_q == LOAD);
  assign done       = (state_q == DONE);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign load_count = load_count_q;

endmodule
